// File: rtl/gda_pkg.sv
// gda_pkg: shared definitions for the gda accuracy-control slice.
//   gda_mode_e  : operand-stage accuracy mode (2-bit, matches the mode port encoding)
//   GDA_SIZE    : default adder width
//   GDA_SUBSIZE : default sub-block width
package gda_pkg;

  localparam int GDA_SIZE    = 16;
  localparam int GDA_SUBSIZE = 4;

  typedef enum logic [1:0] {
    GDA_APPROX    = 2'b00,
    GDA_EXACT     = 2'b01,
    GDA_SELECTIVE = 2'b10,
    GDA_BUDGET    = 2'b11
  } gda_mode_e;

endpackage

// File: rtl/gda_risk_detect.sv
// gda_risk_detect: combinational risk vector for the gda.
//   i_a, i_b [SIZE:1]      operands
//   o_risk   [NB-1:1]      o_risk[k] = 1 when sub-block k (bits (k-1)*SUBSIZE+1 .. k*SUBSIZE)
//                          fully propagates, the only case where an approximate carry
//                          into boundary k*SUBSIZE can be wrong.
module gda_risk_detect
  import gda_pkg::*;
#(
  parameter int SIZE    = GDA_SIZE,
  parameter int SUBSIZE = GDA_SUBSIZE
) (
  input  logic [SIZE:1]              i_a,
  input  logic [SIZE:1]              i_b,
  output logic [SIZE/SUBSIZE-1:1]    o_risk
);

  localparam int NB = SIZE / SUBSIZE;

  logic [SIZE:1] w_prop;
  logic          w_unused_top;

  assign w_prop = i_a ^ i_b;

  // The top sub-block feeds no boundary, so its propagate bits are not needed.
  assign w_unused_top = ^w_prop[SIZE:SIZE-SUBSIZE+1];

  always_comb begin
    o_risk = '0;
    for (int unsigned k = 1; k < NB; k++) begin
      o_risk[k] = &w_prop[(k-1)*SUBSIZE+1 +: SUBSIZE];
    end
  end

endmodule

// File: rtl/gda_accuracy_ctrl.sv
// gda_accuracy_ctrl: operand stage in front of the gracefully-degrading adder.
// Accepts a/b/cin on a valid/ready handshake, chooses the per-boundary exact/approximate
// carry control from the accuracy mode, and holds the result in a one-entry output register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b, in_cin       operands and carry-in
//   mode                     gda_mode_e encoding, sampled on accept
//   budget, window           BUDGET-mode allowance per window of accepts (window 0 = never refill)
//   out_valid/out_ready      downstream handshake
//   out_a, out_b, out_cin    registered operands
//   out_control [NB-1:1]     1 = exact carry at boundary k*SUBSIZE
//   out_risky                some fully-propagating sub-block left approximate
// Optional (macro GDA_CTRL_STATS_EN):
//   stat_total, stat_risky   saturating counts of accepts / accepts with out_risky=1
module gda_accuracy_ctrl
  import gda_pkg::*;
#(
  parameter int SIZE    = GDA_SIZE,
  parameter int SUBSIZE = GDA_SUBSIZE,
  parameter int CW      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE:1]            in_a,
  input  logic [SIZE:1]            in_b,
  input  logic                     in_cin,
  input  logic [1:0]               mode,
  input  logic [CW-1:0]            budget,
  input  logic [CW-1:0]            window,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE:1]            out_a,
  output logic [SIZE:1]            out_b,
  output logic                     out_cin,
  output logic [SIZE/SUBSIZE-1:1]  out_control,
  output logic                     out_risky
`ifdef GDA_CTRL_STATS_EN
  ,
  output logic [31:0]              stat_total,
  output logic [31:0]              stat_risky
`endif
);

  localparam int NB = SIZE / SUBSIZE;

  logic            r_out_valid;
  logic [SIZE:1]   r_out_a;
  logic [SIZE:1]   r_out_b;
  logic            r_out_cin;
  logic [NB-1:1]   r_out_control;
  logic            r_out_risky;
  logic [CW-1:0]   r_used_cnt;
  logic [CW-1:0]   r_win_cnt;

  logic            w_accept;
  logic [NB-1:1]   w_risk;
  logic [NB-1:1]   w_control;
  logic            w_charge;
  logic            w_risky;
  logic            w_win_wrap;
  gda_mode_e       w_mode;

  gda_risk_detect #(
    .SIZE    (SIZE),
    .SUBSIZE (SUBSIZE)
  ) u_risk (
    .i_a    (in_a),
    .i_b    (in_b),
    .o_risk (w_risk)
  );

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_mode   = gda_mode_e'(mode);

  always_comb begin
    w_control = '0;
    w_charge  = 1'b0;
    case (w_mode)
      GDA_APPROX:    w_control = '0;
      GDA_EXACT:     w_control = '1;
      GDA_SELECTIVE: w_control = w_risk;
      GDA_BUDGET: begin
        // Only risky transactions spend allowance; budget=0 degenerates to SELECTIVE.
        if ((|w_risk) && (r_used_cnt < budget)) begin
          w_control = '0;
          w_charge  = 1'b1;
        end else begin
          w_control = w_risk;
        end
      end
      default:       w_control = '0;
    endcase
  end

  assign w_risky    = |(w_risk & ~w_control);
  assign w_win_wrap = (window != '0) && (r_win_cnt == window - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_out_cin     <= 1'b0;
      r_out_control <= '0;
      r_out_risky   <= 1'b0;
      r_used_cnt    <= '0;
      r_win_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_a       <= in_a;
        r_out_b       <= in_b;
        r_out_cin     <= in_cin;
        r_out_control <= w_control;
        r_out_risky   <= w_risky;
        // The decision above used the pre-clear used count; the wrap clear wins over the charge.
        if (w_win_wrap) begin
          r_win_cnt  <= '0;
          r_used_cnt <= '0;
        end else begin
          if (r_win_cnt != '1) r_win_cnt <= r_win_cnt + CW'(1);
          if (w_charge && (r_used_cnt != '1)) r_used_cnt <= r_used_cnt + CW'(1);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_cin     = r_out_cin;
  assign out_control = r_out_control;
  assign out_risky   = r_out_risky;

`ifdef GDA_CTRL_STATS_EN
  logic [31:0] r_stat_total;
  logic [31:0] r_stat_risky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_total <= '0;
      r_stat_risky <= '0;
    end else if (w_accept) begin
      if (r_stat_total != '1) r_stat_total <= r_stat_total + 32'd1;
      if (w_risky && (r_stat_risky != '1)) r_stat_risky <= r_stat_risky + 32'd1;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_risky = r_stat_risky;
`endif

endmodule

// File: tb/tb_gda_accuracy_ctrl.sv
// Bench for gda_accuracy_ctrl (SIZE=16, SUBSIZE=4, CW=8). A transaction-level model
// recomputes every accepted decision from the operand bits with integer arithmetic;
// a negedge process compares the DUT against it, and directed literals pin the model.
module tb_gda_accuracy_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:1] in_a, in_b;
  logic        in_cin;
  logic [1:0]  mode;
  logic [7:0]  budget, window;
  logic        out_valid;
  logic        out_ready;
  logic [16:1] out_a, out_b;
  logic        out_cin;
  logic [3:1]  out_control;
  logic        out_risky;
`ifdef GDA_CTRL_STATS_EN
  logic [31:0] stat_total, stat_risky;
`endif

  always #5 clk = ~clk;

  gda_accuracy_ctrl #(.SIZE(16), .SUBSIZE(4), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .mode        (mode),
    .budget      (budget),
    .window      (window),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_cin     (out_cin),
    .out_control (out_control),
    .out_risky   (out_risky)
`ifdef GDA_CTRL_STATS_EN
    ,
    .stat_total  (stat_total),
    .stat_risky  (stat_risky)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid;
  logic [15:0] m_a, m_b;
  bit          m_cin;
  int          m_ctrl;
  bit          m_risky;
  int          m_used, m_win;
  int          m_tot, m_rsk;

  // Bit (k-1) of the result is boundary k: set when nibble k-1 of a^b is all ones.
  function automatic int risk_of(input int x);
    int r = 0;
    for (int k = 1; k <= 3; k++)
      if (((x >> ((k - 1) * 4)) & 15) == 15) r = r | (1 << (k - 1));
    return r;
  endfunction

  always @(posedge clk) begin
    int r, c;
    if (rst) begin
      m_valid = 0; m_a = 0; m_b = 0; m_cin = 0; m_ctrl = 0; m_risky = 0;
      m_used = 0; m_win = 0; m_tot = 0; m_rsk = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      r = risk_of(int'(in_a ^ in_b));
      c = 0;
      case (mode)
        2'd0: c = 0;
        2'd1: c = 7;
        2'd2: c = r;
        default: begin
          if (r != 0 && m_used < int'(budget)) begin
            c = 0;
            if (m_used < 255) m_used++;
          end else c = r;
        end
      endcase
      if (window != 0 && m_win == int'(window) - 1) begin
        m_win = 0; m_used = 0;
      end else if (m_win < 255) m_win++;
      m_risky = (r & ~c & 7) != 0;
      m_ctrl  = c;
      m_valid = 1; m_a = in_a; m_b = in_b; m_cin = in_cin;
      m_tot++;
      if (m_risky) m_rsk++;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_a", 32'(out_a), 32'(m_a));
        check("out_b", 32'(out_b), 32'(m_b));
        check("out_cin", 32'(out_cin), 32'(m_cin));
        check("out_control", 32'(out_control), 32'(m_ctrl));
        check("out_risky", 32'(out_risky), 32'(m_risky));
      end
`ifdef GDA_CTRL_STATS_EN
      check("stat_total", stat_total, 32'(m_tot));
      check("stat_risky", stat_risky, 32'(m_rsk));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    int guard = 0;
    in_valid = 1'b1; mode = md; in_a = a; in_b = b; in_cin = c;
    @(negedge clk); #1;
    while (!in_ready && guard < 20) begin
      guard++;
      if (guard >= 3) out_ready = 1'b1;
      @(negedge clk); #1;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    mode = 2'd0; budget = 8'd0; window = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_control", 32'(out_control), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1; chk_en = 1'b1;

    send(2'd2, 16'h0FFF, 16'h0000, 1'b0);
    check("sel_full_ctrl", 32'(out_control), 32'h7);
    check("sel_full_risky", 32'(out_risky), 32'd0);
    send(2'd2, 16'h00F0, 16'h0000, 1'b1);
    check("sel_mid_ctrl", 32'(out_control), 32'h2);
    check("sel_mid_cin", 32'(out_cin), 32'd1);
    send(2'd0, 16'h0FFF, 16'h0000, 1'b0);
    check("approx_ctrl", 32'(out_control), 32'h0);
    check("approx_risky", 32'(out_risky), 32'd1);
    send(2'd1, 16'h0000, 16'h0000, 1'b0);
    check("exact_ctrl", 32'(out_control), 32'h7);
    check("exact_risky", 32'(out_risky), 32'd0);
    send(2'd0, 16'hF0F0, 16'h0F0F, 1'b0);
    check("approx_allprop_risky", 32'(out_risky), 32'd1);
    send(2'd2, 16'h000F, 16'h000E, 1'b0);
    check("sel_noprop_ctrl", 32'(out_control), 32'h0);
    budget = 8'd0;
    send(2'd3, 16'h0FFF, 16'h0000, 1'b0);
    check("bud0_ctrl", 32'(out_control), 32'h7);

    // Budget window from a clean counter state.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    budget = 8'd2; window = 8'd4;
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("bud_ctrl1", 32'(out_control), 32'h0);
    check("bud_risky1", 32'(out_risky), 32'd1);
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("bud_ctrl2", 32'(out_control), 32'h0);
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("bud_ctrl3", 32'(out_control), 32'h2);
    check("bud_risky3", 32'(out_risky), 32'd0);
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("bud_ctrl4", 32'(out_control), 32'h2);
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("bud_ctrl5_refill", 32'(out_control), 32'h0);

    // Backpressure: held output must not change and upstream must stall.
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'd1; in_a = 16'h1234; in_b = 16'h0001; in_cin = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_a", 32'(out_a), 32'h00F0);
      check("bp_out_control", 32'(out_control), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_a", 32'(out_a), 32'h1234);
    check("bp_new_ctrl", 32'(out_control), 32'h7);

    // Reset while a transaction is held.
    out_ready = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef GDA_CTRL_STATS_EN
    check("midrst_stat_total", stat_total, 32'd0);
    check("midrst_stat_risky", stat_risky, 32'd0);
`endif
    out_ready = 1'b1;
    budget = 8'd1; window = 8'd0;
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("midrst_used_cleared", 32'(out_control), 32'h0);
    send(2'd3, 16'h00F0, 16'h0000, 1'b0);
    check("midrst_bud_exhausted", 32'(out_control), 32'h2);

    // Mixed traffic with intermittent backpressure, checked against the model.
    budget = 8'd3; window = 8'd5;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b = a ^ 16'h0FFF ^ 16'($urandom_range(0, 1) << 4);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end else begin
        send(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
